servo_calib_seq: RTL and testbench

- Homing sequencer for the balance-platform servo; started by `calib_start` from the game control unit.
- Sweeps the servo position target down, one step at a time, until the end-of-travel sensor (`sensorFimCurso`) is confirmed by debouncing, then latches the home position.
- Moves the servo to a centre position offset from home and signals completion.
- Sole driver of the servo position target while calibrating; the PWM generator consumes `pos_out`.

---
 rtl/servo_calib_seq_if.sv | 25 ++
 rtl/servo_calib_seq.sv | 160 ++++++++++++++++
 tb/tb_servo_calib_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/servo_calib_seq_if.sv
// Control-unit <-> homing sequencer signal bundle.
//   master : control unit / bench side (drives calib_start, sensorFimCurso)
//   slave  : servo_calib_seq side (drives position, status and state code)
interface servo_calib_seq_if #(
   parameter int POS_W = 10
);
   logic             calib_start;
   logic             sensorFimCurso;
   logic [POS_W-1:0] pos_out;
   logic [POS_W-1:0] home_pos;
   logic             calib_done;
   logic             calib_err;
   logic             busy;
   logic [2:0]       db_estado;

   modport master (
      output calib_start, sensorFimCurso,
      input  pos_out, home_pos, calib_done, calib_err, busy, db_estado
   );

   modport slave (
      input  calib_start, sensorFimCurso,
      output pos_out, home_pos, calib_done, calib_err, busy, db_estado
   );
endinterface

// File: rtl/servo_calib_seq.sv
// Servo homing sequencer: sweeps the position target down until the
// debounced end-of-travel sensor fires, latches that as home, then moves
// to home+CENTER_OFFSET (saturated at POS_MAX) and reports done.
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   bus (slave)    : calib_start, sensorFimCurso in;
//                    pos_out, home_pos, calib_done, calib_err, busy,
//                    db_estado out
module servo_calib_seq #(
   parameter int POS_W         = 10,
   parameter int POS_MIN       = 0,
   parameter int POS_MAX       = 1000,
   parameter int STEP_DIV      = 50000,
   parameter int DEBOUNCE      = 16,
   parameter int CENTER_OFFSET = 200
) (
   input  logic              clock,
   input  logic              reset,
   servo_calib_seq_if.slave  bus
);

   localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE + 1);

   localparam logic [POS_W-1:0] LP_POS_MAX   = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0] LP_POS_MIN   = POS_W'(POS_MIN);
   localparam logic [POS_W:0]   LP_MAX_EXT   = (POS_W+1)'(POS_MAX);
   localparam logic [POS_W:0]   LP_OFFSET    = (POS_W+1)'(CENTER_OFFSET);
   localparam logic [CNT_W-1:0] LP_STEP_LAST = CNT_W'(STEP_DIV - 1);
   localparam logic [DB_W-1:0]  LP_DEBOUNCE  = DB_W'(DEBOUNCE);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DESCEND  = 3'd1,
      S_DEBOUNCE = 3'd2,
      S_CENTER   = 3'd3,
      S_DONE     = 3'd4,
      S_ERRO     = 3'd5
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [POS_W-1:0] r_pos, w_pos_nxt;
   logic [POS_W-1:0] r_home, w_home_nxt;
   logic [DB_W-1:0]  r_db_cnt, w_db_cnt_nxt;
   logic [DB_W-1:0]  w_db_inc;
   logic [CNT_W-1:0] r_step_cnt;
   logic             r_s_meta, r_s_sync;
   logic             r_start_q;
   logic             w_rise;
   logic             w_tick;
   logic [POS_W:0]   w_sum;
   logic [POS_W-1:0] w_target;

   assign w_rise   = bus.calib_start & ~r_start_q;
   assign w_tick   = (r_step_cnt == LP_STEP_LAST);
   assign w_db_inc = r_db_cnt + DB_W'(1);

   // Centre target computed one bit wider so the offset cannot wrap.
   assign w_sum    = {1'b0, r_home} + LP_OFFSET;
   assign w_target = (w_sum > LP_MAX_EXT) ? LP_POS_MAX : w_sum[POS_W-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s_meta  <= 1'b0;
         r_s_sync  <= 1'b0;
         r_start_q <= 1'b0;
      end else begin
         r_s_meta  <= bus.sensorFimCurso;
         r_s_sync  <= r_s_meta;
         r_start_q <= bus.calib_start;
      end
   end

   // Step divider restarts from zero on every state entry, so the first
   // step after entering Descend/Center is always a full STEP_DIV away.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_step_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         r_step_cnt <= '0;
      end else if (r_state == S_DESCEND || r_state == S_CENTER) begin
         r_step_cnt <= w_tick ? '0 : r_step_cnt + CNT_W'(1);
      end else begin
         r_step_cnt <= '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_pos    <= LP_POS_MAX;
         r_home   <= '0;
         r_db_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pos    <= w_pos_nxt;
         r_home   <= w_home_nxt;
         r_db_cnt <= w_db_cnt_nxt;
      end
   end

   // Abort (calib_start low) is tested first in the active states so it
   // outranks a sensor hit or step tick in the same cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_pos_nxt    = r_pos;
      w_home_nxt   = r_home;
      w_db_cnt_nxt = r_db_cnt;
      case (r_state)
         S_IDLE, S_DONE, S_ERRO: begin
            if (w_rise) begin
               w_state_nxt = S_DESCEND;
               w_pos_nxt   = LP_POS_MAX;
            end
         end
         S_DESCEND: begin
            if (!bus.calib_start) begin
               w_state_nxt = S_IDLE;
            end else if (r_s_sync) begin
               w_state_nxt  = S_DEBOUNCE;
               w_db_cnt_nxt = DB_W'(1);
            end else if (w_tick) begin
               if (r_pos == LP_POS_MIN) w_state_nxt = S_ERRO;
               else                     w_pos_nxt   = r_pos - POS_W'(1);
            end
         end
         S_DEBOUNCE: begin
            if (!bus.calib_start) begin
               w_state_nxt = S_IDLE;
            end else if (!r_s_sync) begin
               w_state_nxt = S_DESCEND;
            end else begin
               w_db_cnt_nxt = w_db_inc;
               if (w_db_inc >= LP_DEBOUNCE) begin
                  w_home_nxt  = r_pos;
                  w_state_nxt = S_CENTER;
               end
            end
         end
         S_CENTER: begin
            if (!bus.calib_start) begin
               w_state_nxt = S_IDLE;
            end else if (w_tick) begin
               if (r_pos == w_target) w_state_nxt = S_DONE;
               else                   w_pos_nxt   = r_pos + POS_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.pos_out    = r_pos;
   assign bus.home_pos   = r_home;
   assign bus.db_estado  = r_state;
   assign bus.calib_done = (r_state == S_DONE);
   assign bus.calib_err  = (r_state == S_ERRO);
   assign bus.busy       = (r_state == S_DESCEND) || (r_state == S_DEBOUNCE) ||
                           (r_state == S_CENTER);

endmodule

// File: tb/tb_servo_calib_seq.sv
// Scoreboard bench for servo_calib_seq (POS_W=5, POS_MAX=20, STEP_DIV=4,
// DEBOUNCE=3, CENTER_OFFSET=5). Every change of state/pos_out/home_pos is
// an output event; the expected event list, including the cycle spacing
// from the previous event, is queued by the stimulus process.
module tb_servo_calib_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   servo_calib_seq_if #(.POS_W(5)) bus ();

   servo_calib_seq #(
      .POS_W(5), .POS_MIN(0), .POS_MAX(20), .STEP_DIV(4),
      .DEBOUNCE(3), .CENTER_OFFSET(5)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct {
      int st;
      int pos;
      int home;
      int dt;     // cycles since previous event; 0 = not checked
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push(input int st, input int pos, input int home, input int dt);
      exp_t e;
      e.st = st; e.pos = pos; e.home = home; e.dt = dt;
      q.push_back(e);
   endtask

   task automatic wait_pos(input int v);
      int n = 0;
      while (int'(bus.pos_out) != v && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         $display("FAIL wait_pos timeout: pos_out=%0d, expected %0d", bus.pos_out, v);
      end
   endtask

   task automatic wait_state(input int v);
      int n = 0;
      while (int'(bus.db_estado) != v && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         $display("FAIL wait_state timeout: db_estado=%0d, expected %0d", bus.db_estado, v);
      end
   endtask

   task automatic restart();
      bus.calib_start = 1'b0;
      @(negedge clk);
      bus.calib_start = 1'b1;
   endtask

   // Monitor: compares each output event against the queue head.
   initial begin
      int   cyc = 0;
      int   last = 0;
      bit   first = 1'b1;
      int   ps = 0, pp = 0, ph = 0;
      exp_t e;
      wait (rst == 1'b0);
      forever begin
         if (first || int'(bus.db_estado) != ps || int'(bus.pos_out) != pp ||
             int'(bus.home_pos) != ph) begin
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_event: state=%0d pos=%0d home=%0d, expected no event",
                        bus.db_estado, bus.pos_out, bus.home_pos);
            end else begin
               e = q.pop_front();
               chk("db_estado",  int'(bus.db_estado),  e.st);
               chk("pos_out",    int'(bus.pos_out),    e.pos);
               chk("home_pos",   int'(bus.home_pos),   e.home);
               chk("calib_done", int'(bus.calib_done), (e.st == 4) ? 1 : 0);
               chk("calib_err",  int'(bus.calib_err),  (e.st == 5) ? 1 : 0);
               chk("busy",       int'(bus.busy),       (e.st >= 1 && e.st <= 3) ? 1 : 0);
               if (e.dt != 0) chk("event_spacing", cyc - last, e.dt);
            end
            first = 1'b0;
            last  = cyc;
            ps = int'(bus.db_estado);
            pp = int'(bus.pos_out);
            ph = int'(bus.home_pos);
         end
         @(negedge clk);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.calib_start    = 1'b0;
      bus.sensorFimCurso = 1'b0;

      // 1: reset state
      push(0, 20, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 2: real hit at 12, centre ramps to 17
      push(1, 20, 0, 0);
      for (int p = 19; p >= 12; p--) push(1, p, 0, 4);
      push(2, 12, 0, 3);
      push(3, 12, 12, 2);
      for (int p = 13; p <= 17; p++) push(3, p, 12, 4);
      push(4, 17, 12, 4);
      bus.calib_start = 1'b1;
      wait_pos(12);
      bus.sensorFimCurso = 1'b1;
      wait_state(3);
      bus.sensorFimCurso = 1'b0;
      wait_state(4);
      repeat (3) @(negedge clk);

      // 3: recalibrate from Done; 2-cycle glitch at 15, real hit at 10
      push(1, 20, 12, 0);
      for (int p = 19; p >= 15; p--) push(1, p, 12, 4);
      push(2, 15, 12, 3);
      push(1, 15, 12, 2);
      for (int p = 14; p >= 10; p--) push(1, p, 12, 4);
      push(2, 10, 12, 3);
      push(3, 10, 10, 2);
      for (int p = 11; p <= 15; p++) push(3, p, 10, 4);
      push(4, 15, 10, 4);
      restart();
      wait_pos(15);
      bus.sensorFimCurso = 1'b1;
      repeat (2) @(negedge clk);
      bus.sensorFimCurso = 1'b0;
      wait_pos(10);
      bus.sensorFimCurso = 1'b1;
      wait_state(3);
      bus.sensorFimCurso = 1'b0;
      wait_state(4);
      repeat (3) @(negedge clk);

      // 4: no sensor, sweep to 0 then Erro; low start ignored, rise restarts
      push(1, 20, 10, 0);
      for (int p = 19; p >= 0; p--) push(1, p, 10, 4);
      push(5, 0, 10, 4);
      restart();
      wait_state(5);
      bus.calib_start = 1'b0;
      repeat (4) @(negedge clk);
      push(1, 20, 10, 0);
      bus.calib_start = 1'b1;

      // 5: abort at 16
      for (int p = 19; p >= 16; p--) push(1, p, 10, 4);
      push(0, 16, 10, 1);
      wait_pos(16);
      bus.calib_start = 1'b0;
      wait_state(0);
      repeat (3) @(negedge clk);

      // 6: hit at 18, target saturates at 20; rise from Done; final abort
      push(1, 20, 10, 0);
      push(1, 19, 10, 4);
      push(1, 18, 10, 4);
      push(2, 18, 10, 3);
      push(3, 18, 18, 2);
      push(3, 19, 18, 4);
      push(3, 20, 18, 4);
      push(4, 20, 18, 4);
      bus.calib_start = 1'b1;
      wait_pos(18);
      bus.sensorFimCurso = 1'b1;
      wait_state(3);
      bus.sensorFimCurso = 1'b0;
      wait_state(4);
      repeat (3) @(negedge clk);
      push(1, 20, 18, 0);
      push(1, 19, 18, 4);
      push(0, 19, 18, 1);
      restart();
      wait_pos(19);
      bus.calib_start = 1'b0;
      wait_state(0);

      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", q.size());
      end
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
